demux12: RTL and testbench

Two-way pixel-stream demultiplexer for the adaptive median filter datapath. It steers one valid/ready pixel stream to one of two downstream consumers, for example the 3x3 window stage or the bypass/larger-window stage. Routing is chosen per packet (one line or frame, terminated by `s_last`) and held for the whole packet. Each output has a 2-entry buffer, so every output is registered and no combinational path runs from any `m*_ready` to `s_ready`.

---
 rtl/demux12.sv | 135 +++++++++++++
 tb/tb_demux12.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux12.sv
// Two-way valid/ready pixel demultiplexer with per-packet routing and 2-entry output FIFOs.
// Optional packet counters on each output are enabled by defining DEMUX12_STATS_EN.
module demux12 #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             s_sel,
  output logic             s_ready,
  output logic [W-1:0]     m0_data,
  output logic             m0_last,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [W-1:0]     m1_data,
  output logic             m1_last,
  output logic             m1_valid,
`ifdef DEMUX12_STATS_EN
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
`endif
  input  logic             m1_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_sel_q;
  logic       w_sel_nxt;
  logic       r_run;
  logic       w_route;
  logic       w_acc;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_valid;
  logic [1:0] w_full;
  logic [1:0] w_m_ready;
  logic [W:0] w_head [2];

  // Route follows s_sel only on the first beat of a packet; afterwards it is held.
  assign w_route   = (r_state == IDLE) ? s_sel : r_sel_q;
  assign s_ready   = r_run & ~w_full[w_route];
  assign w_acc     = s_valid & s_ready;
  assign w_push    = {w_acc & w_route, w_acc & ~w_route};
  assign w_m_ready = {m1_ready, m0_ready};
  assign w_pop     = w_valid & w_m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel_q <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel_q <= w_sel_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel_q;
    case (r_state)
      IDLE: begin
        if (w_acc && !s_last) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = s_sel;
        end
      end
      BUSY: begin
        if (w_acc && s_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [W:0] r_ent0;
    logic [W:0] r_ent1;
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ent0 <= '0;
        r_ent1 <= '0;
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
        r_cnt  <= 2'd0;
      end else begin
        if (w_push[gi]) begin
          if (r_wptr) r_ent1 <= {s_last, s_data};
          else        r_ent0 <= {s_last, s_data};
          r_wptr <= ~r_wptr;
        end
        if (w_pop[gi]) r_rptr <= ~r_rptr;
        if (w_push[gi] && !w_pop[gi])      r_cnt <= r_cnt + 2'd1;
        else if (!w_push[gi] && w_pop[gi]) r_cnt <= r_cnt - 2'd1;
      end
    end

    assign w_valid[gi] = (r_cnt != 2'd0);
    assign w_full[gi]  = (r_cnt == 2'd2);
    assign w_head[gi]  = r_rptr ? r_ent1 : r_ent0;

`ifdef DEMUX12_STATS_EN
    logic [CNT_W-1:0] r_pkt_cnt;

    // Counts packets as they leave the output, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_pkt_cnt <= '0;
      else if (w_pop[gi] && w_head[gi][W]) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
`endif
  end

  assign m0_valid = w_valid[0];
  assign m1_valid = w_valid[1];
  assign {m0_last, m0_data} = w_head[0];
  assign {m1_last, m1_data} = w_head[1];

`ifdef DEMUX12_STATS_EN
  assign pkt_cnt0 = g_fifo[0].r_pkt_cnt;
  assign pkt_cnt1 = g_fifo[1].r_pkt_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_demux12.sv
// Self-checking bench for demux12: directed scenarios plus random traffic against a queue-based model.
module tb_demux12;
`ifdef DEMUX12_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 0;
  logic rst_n = 0;
  logic [7:0] s_data = 0;
  logic s_valid = 0, s_last = 0, s_sel = 0;
  logic s_ready;
  logic [7:0] m0_data, m1_data;
  logic m0_last, m1_last, m0_valid, m1_valid;
  logic m0_ready = 1, m1_ready = 1;
`ifdef DEMUX12_STATS_EN
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  demux12 #(.W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_sel(s_sel), .s_ready(s_ready),
    .m0_data(m0_data), .m0_last(m0_last), .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m1_data(m1_data), .m1_last(m1_last), .m1_valid(m1_valid),
`ifdef DEMUX12_STATS_EN
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
    .m1_ready(m1_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per output, plus "inside a packet" flag and its held route.
  logic [8:0] q0[$], q1[$];
  bit m_in_pkt, m_pkt_sel, m_run;
  int unsigned mc0, mc1;

  function automatic bit m_route();
    return m_in_pkt ? m_pkt_sel : s_sel;
  endfunction

  function automatic bit m_ready();
    if (!m_run || !rst_n) return 1'b0;
    return m_route() ? (q1.size() < 2) : (q0.size() < 2);
  endfunction

  task automatic m_clear();
    q0.delete(); q1.delete();
    m_in_pkt = 0; m_pkt_sel = 0; m_run = 0; mc0 = 0; mc1 = 0;
  endtask

  task automatic m_step();
    bit acc, r;
    if (!rst_n) begin m_clear(); return; end
    acc = s_valid && m_ready();
    r = m_route();
    if (q0.size() > 0 && m0_ready) begin if (q0[0][8]) mc0++; void'(q0.pop_front()); end
    if (q1.size() > 0 && m1_ready) begin if (q1[0][8]) mc1++; void'(q1.pop_front()); end
    if (acc) begin
      if (r) q1.push_back({s_last, s_data}); else q0.push_back({s_last, s_data});
      if (!m_in_pkt && !s_last) begin m_in_pkt = 1; m_pkt_sel = s_sel; end
      else if (m_in_pkt && s_last) m_in_pkt = 0;
    end
    m_run = 1;
  endtask

  initial begin
    m_clear();
    forever begin
      @(negedge clk); #2;
      if (!rst_n) m_clear();
      chk("s_ready", s_ready, m_ready());
      chk("m0_valid", m0_valid, q0.size() > 0);
      chk("m1_valid", m1_valid, q1.size() > 0);
      if (q0.size() > 0) begin chk("m0_data", m0_data, q0[0][7:0]); chk("m0_last", m0_last, q0[0][8]); end
      else if (!rst_n) begin chk("m0_data_rst", m0_data, 0); chk("m0_last_rst", m0_last, 0); end
      if (q1.size() > 0) begin chk("m1_data", m1_data, q1[0][7:0]); chk("m1_last", m1_last, q1[0][8]); end
      else if (!rst_n) begin chk("m1_data_rst", m1_data, 0); chk("m1_last_rst", m1_last, 0); end
`ifdef DEMUX12_STATS_EN
      chk("pkt_cnt0", pkt_cnt0, mc0 % (1 << CNT_W));
      chk("pkt_cnt1", pkt_cnt1, mc1 % (1 << CNT_W));
`endif
      @(posedge clk);
      m_step();
    end
  end

  // Presents one beat and returns at the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic l, input logic sel);
    int n = 0;
    @(negedge clk);
    s_valid = 1; s_data = d; s_last = l; s_sel = sel;
    #1;
    while (!s_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; s_valid = 0;
    #1;
    chk("rst_m0_valid", m0_valid, 0);
    chk("rst_m1_valid", m1_valid, 0);
    chk("rst_s_ready", s_ready, 0);
`ifdef DEMUX12_STATS_EN
    chk("rst_pkt_cnt0", pkt_cnt0, 0);
    chk("rst_pkt_cnt1", pkt_cnt1, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rel_s_ready_low", s_ready, 0);
    @(posedge clk);
    #1 chk("rel_s_ready_high", s_ready, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cstart;
    logic [7:0] exp_d;
    do_reset();

    // Routing and latency: route is held at 1 despite s_sel toggling
    m0_ready = 1; m1_ready = 1;
    cstart = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'h10 + 8'(k);
      send(exp_d, k == 3, (k == 0) ? 1'b1 : 1'(k % 2 == 0));
      #1;
      chk("route_m1_valid", m1_valid, 1);
      chk("route_m1_data", m1_data, exp_d);
      chk("route_m1_last", m1_last, k == 3);
      chk("route_m0_valid", m0_valid, 0);
    end
    chk("route_rate", cyc - cstart, 4);
    idle();

    // Back-to-back packets with no bubble at the boundary
    cstart = cyc + 1;
    send(8'hAA, 1, 0); #1;
    chk("b2b_m0_data", m0_data, 8'hAA); chk("b2b_m0_last", m0_last, 1);
    send(8'h55, 0, 1); #1;
    chk("b2b_m1_data", m1_data, 8'h55);
    send(8'h56, 1, 0); #1;
    chk("b2b_m1_data2", m1_data, 8'h56); chk("b2b_m1_last", m1_last, 1);
    chk("b2b_rate", cyc - cstart, 3);
    idle();

    // Stall on m0
    m0_ready = 0;
    send(8'h20, 0, 0);
    send(8'h21, 0, 0);
    @(negedge clk);
    s_valid = 1; s_data = 8'h22; s_last = 0; s_sel = 0;
    #1 chk("stall_ready", s_ready, 0);
    repeat (3) begin @(negedge clk); #1 chk("stall_hold", s_ready, 0); end
    m0_ready = 1;
    send(8'h22, 0, 0);
    send(8'h23, 1, 0);
    idle();
    repeat (3) @(negedge clk);

    // Independent outputs: m1 stalled and full, m0 still at full rate
    m1_ready = 0;
    send(8'h30, 0, 1);
    send(8'h31, 1, 1);
    #1 cstart = cyc;
    send(8'h32, 0, 0);
    send(8'h33, 0, 0);
    send(8'h34, 1, 0);
    #1 chk("indep_rate", cyc - cstart, 3);
    @(negedge clk);
    s_valid = 1; s_data = 8'h35; s_last = 1; s_sel = 1;
    #1 chk("indep_block", s_ready, 0);
    m1_ready = 1;
    send(8'h35, 1, 1);
    idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a packet to m1
    send(8'h50, 0, 1);
    send(8'h51, 0, 1);
    do_reset();
    send(8'h40, 0, 0); #1;
    chk("post_rst_m0_data", m0_data, 8'h40);
    chk("post_rst_m1_valid", m1_valid, 0);
    send(8'h41, 1, 1); #1;
    chk("post_rst_held", m0_data, 8'h41);
    idle();
    repeat (2) @(negedge clk);

`ifdef DEMUX12_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(8'h60 + 8'(k), 1, 0);
      @(posedge clk);
      #1;
      chk("wrap_cnt0", pkt_cnt0, (k + 1) % 4);
      chk("wrap_cnt1", pkt_cnt1, 0);
    end
    idle();
`endif

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      s_valid  = ($urandom_range(0, 3) != 0);
      s_data   = 8'($urandom);
      s_last   = ($urandom_range(0, 3) == 0);
      s_sel    = 1'($urandom);
      m0_ready = ($urandom_range(0, 3) != 0);
      m1_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    s_valid = 0; m0_ready = 1; m1_ready = 1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
